// File: rtl/fcs_append_parallel.sv
`timescale 1ns/1ps
// Transmit-side Ethernet FCS inserter: forwards a frame byte stream, zero-pads it to MIN_LEN
// bytes, then appends the inverted reflected CRC-32 (low byte first) behind a single output stage.
module fcs_append_parallel #(
  parameter int MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       frame_abort
);
  localparam int CW = (MIN_LEN < 1) ? 1 : $clog2(MIN_LEN + 1);
  localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_LEN);
  localparam logic [31:0]   CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]   CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_PAD, ST_FCS} state_t;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic            frame_abort_q, frame_abort_d;
  logic [31:0]     crc_q, crc_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [1:0]      idx_q, idx_d;

  logic            load, accept, start, fwd, short_frame;
  logic [CW-1:0]   in_cnt, pad_cnt;
  logic [31:0]     fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Byte count saturates at MIN_LEN so long frames never overflow it.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c >= MIN_CNT) ? c : c + 1'b1;
  endfunction

  assign load        = !out_valid_q || out_ready;
  assign in_ready    = ((state_q == ST_IDLE) || (state_q == ST_PAYLOAD)) && load;
  assign accept      = in_valid && in_ready;
  assign start       = accept && in_sof;
  assign fwd         = accept && !in_sof && (state_q == ST_PAYLOAD);
  assign in_cnt      = cnt_inc(start ? '0 : byte_cnt_q);
  assign pad_cnt     = byte_cnt_q + 1'b1;
  assign short_frame = in_cnt < MIN_CNT;
  assign fcs         = ~crc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'd0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      crc_q         <= CRC_INIT;
      byte_cnt_q    <= '0;
      idx_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      frame_abort_q <= frame_abort_d;
      crc_q         <= crc_d;
      byte_cnt_q    <= byte_cnt_d;
      idx_q         <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start || fwd) begin
      if (in_eof) state_d = short_frame ? ST_PAD : ST_FCS;
      else        state_d = ST_PAYLOAD;
    end else if (state_q == ST_PAD && load && pad_cnt >= MIN_CNT) begin
      state_d = ST_FCS;
    end else if (state_q == ST_FCS && load && idx_q == 2'd3) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sof_d     = out_sof_q;
    out_eof_d     = out_eof_q;
    frame_abort_d = 1'b0;
    crc_d         = crc_q;
    byte_cnt_d    = byte_cnt_q;
    idx_d         = idx_q;
    if (load) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end
    if (start || fwd) begin
      // A restart mid-frame drops the old frame; the CRC is reseeded from init.
      out_valid_d   = 1'b1;
      out_data_d    = in_data;
      out_sof_d     = start;
      crc_d         = crc_byte(start ? CRC_INIT : crc_q, in_data);
      byte_cnt_d    = in_cnt;
      frame_abort_d = start && (state_q == ST_PAYLOAD);
    end else if (state_q == ST_PAD && load) begin
      out_valid_d = 1'b1;
      out_data_d  = 8'h00;
      crc_d       = crc_byte(crc_q, 8'h00);
      byte_cnt_d  = pad_cnt;
    end else if (state_q == ST_FCS && load) begin
      out_valid_d = 1'b1;
      out_data_d  = fcs[{idx_q, 3'b000} +: 8];
      out_eof_d   = (idx_q == 2'd3);
      idx_d       = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        crc_d      = CRC_INIT;
        byte_cnt_d = '0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign frame_abort = frame_abort_q;

endmodule
